fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling instruction buffer between the fetch stage and decode (D) stage of the pipelined MIPS core.
- Captures the fetch stage's {Now_PC, Instr} pair every cycle it has room, and presents entries in order to decode.
- Generates npc_stall back to the fetch stage when full.
- Supports whole-queue flush on control-flow redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- F_PC  input  32  Now_PC from fetch stage.
- F_Instr  input  32  Instr from fetch stage.
- F_valid  input  1  fetch pair is valid; tied 1 in the current core.
- Flush  input  1  redirect: discard all entries and this cycle's input.
- D_ready  input  1  decode accepts the head entry this cycle.
- npc_stall  output  1  fetch must hold its PC this cycle.
- D_valid  output  1  head entry valid.
- D_PC  output  32  head entry PC.
- D_Instr  output  32  head entry instruction.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit register array {PC, Instr}, wr_ptr and rd_ptr (AW bits, wrap modulo DEPTH), occupancy counter (AW+1 bits).
- Reset is synchronous. On the clock edge with Reset=1:
  - wr_ptr = rd_ptr = count = 0.
  - Array contents are don't-care.
  - Reset overrides Flush, push and pop.
- Outputs are combinational from state only. There is no path from F_* to D_*; minimum latency from push to D_valid is 1 cycle.
- D_valid = (count != 0).
- D_PC / D_Instr = head entry when D_valid, else 32'h0. Empty therefore presents a NOP, sll $0,$0,0.
- pop = D_valid & D_ready & ~Flush.
- push = F_valid & ~Flush & (count != DEPTH | pop). A simultaneous pop frees a slot when full.
- npc_stall = F_valid & (count == DEPTH) & ~pop & ~Flush:
  - Combinational; depends on D_ready.
  - Low during Flush so fetch loads the redirect target.
- Clock edge, with Reset=0:
  - Flush=1: wr_ptr = rd_ptr = count = 0; the F_* pair is dropped.
  - Otherwise, on push: array[wr_ptr] = {F_PC, F_Instr}; wr_ptr += 1.
  - Otherwise, on pop: rd_ptr += 1.
  - count += push - pop. Push and pop together leave count unchanged, including at count==DEPTH and at count==1.
- Push with count==0 and D_ready=1: the entry is not visible until the next cycle. No bypass.
- Pointer wrap: after DEPTH pushes wr_ptr returns to 0. Ordering is preserved across the wrap.
- Flush is not gated by D_ready.
- The redirect controller asserts Flush only when every held entry and the current fetch pair are wrong-path. Delay-slot instructions must already have been popped.
- Invariants, checked by assertion:
  - count <= DEPTH.
  - wr_ptr - rd_ptr == count mod DEPTH.
  - no push when full and not popping.
  - no pop when empty.

Decomposition:
- Shared package constants:
  - RESET_PC = 32'h3000.
  - NOP_INSTR = 32'h0.
  - FQ_DEPTH default = 4.
- Natural sub-module: fq_storage. It is a DEPTH x 64 register file with one write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
- fetch_queue holds pointers, counter, push/pop/stall logic and output muxing.

Test Plan:
- Reset, then F_PC=0x3000/F_Instr=0x24010001, D_ready=0 for 1 cycle -> next cycle D_valid=1, D_PC=0x3000, D_Instr=0x24010001, count=1. In the push cycle D_valid=0, D_Instr=0.
- D_ready=0, push PCs 0x3000,0x3004,0x3008,0x300C -> count=4. Next cycle npc_stall=1; a 5th pair 0x3010 is not stored; count stays 4.
- Full, D_ready=1 with F_PC=0x3010 -> npc_stall=0, pop 0x3000 and push 0x3010 on the same edge. count stays 4; subsequent pops yield 0x3004,0x3008,0x300C,0x3010 (crosses pointer wrap).
- count=3, Flush=1 with D_ready=1 and F_PC=0x3020 -> next cycle count=0, D_valid=0, D_Instr=0. 0x3020 is never output; npc_stall=0 during Flush.
- Streaming: D_ready=1 continuously, PCs 0x3000..0x303C -> each PC output exactly once in order, 1 cycle after push. count stays at 1, npc_stall never asserts.
- Reset asserted mid-stream with count=2 and Flush=1 simultaneously -> next cycle count=0, D_valid=0. The first push after deassert appears at D_PC the following cycle.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants and the entry layout for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC  = 32'h3000;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int          FQ_DEPTH  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// DEPTH x 64 register file: one synchronous write port, one combinational read port.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // Contents need no reset; occupancy tracking decides what is valid.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: in-order queue with full-stall and redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic [31:0]   F_PC,
  input  logic [31:0]   F_Instr,
  input  logic          F_valid,
  input  logic          Flush,
  input  logic          D_ready,
  output logic          npc_stall,
  output logic          D_valid,
  output logic [31:0]   D_PC,
  output logic [31:0]   D_Instr,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          full;
  logic [63:0]   rdata;
  fq_entry_t     head;

  assign full      = (count == FULL);
  assign D_valid   = (count != '0);
  assign pop       = D_valid & D_ready & ~Flush;
  // A same-cycle pop frees the slot, so a full queue can still accept.
  assign push      = F_valid & ~Flush & (~full | pop);
  assign npc_stall = F_valid & full & ~pop & ~Flush;

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .CLK   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({F_PC, F_Instr}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign head    = rdata;
  assign D_PC    = D_valid ? head.pc    : 32'h0;
  assign D_Instr = D_valid ? head.instr : NOP_INSTR;

  always_ff @(posedge CLK) begin
    if (Reset || Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge CLK) disable iff (Reset) count <= FULL);
  a_ptr_diff:    assert property (@(posedge CLK) disable iff (Reset)
                                  (wr_ptr - rd_ptr) == count[AW-1:0]);
  a_no_overflow: assert property (@(posedge CLK) disable iff (Reset) !(push && full && !pop));
  a_no_underflw: assert property (@(posedge CLK) disable iff (Reset) !(pop && !D_valid));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected entries, a monitor checks pops.
module tb_fetch_queue;

  logic        CLK;
  logic        Reset;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_valid;
  logic        Flush;
  logic        D_ready;
  logic        npc_stall;
  logic        D_valid;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;
  int mcount   = 0;
  logic [63:0] exp_q [$];

  fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .F_PC      (F_PC),
    .F_Instr   (F_Instr),
    .F_valid   (F_valid),
    .Flush     (Flush),
    .D_ready   (D_ready),
    .npc_stall (npc_stall),
    .D_valid   (D_valid),
    .D_PC      (D_PC),
    .D_Instr   (D_Instr),
    .count     (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle at the falling edge; the reference model decides push/pop/stall.
  task automatic applyStimulus(input logic rst, input logic fv, input logic fl, input logic dr,
                               input logic [31:0] pc, input logic [31:0] instr);
    logic mpop, mpush, mstall;
    @(negedge CLK);
    Reset   = rst;
    F_valid = fv;
    Flush   = fl;
    D_ready = dr;
    F_PC    = pc;
    F_Instr = instr;
    mpop   = (mcount != 0) && dr && !fl;
    mpush  = fv && !fl && (mcount != 4 || mpop);
    mstall = fv && (mcount == 4) && !mpop && !fl;
    if (rst || fl) exp_q.delete();
    else if (mpush) exp_q.push_back({pc, instr});
    #2;
    if (!rst) begin
      checkOutput("count", 32'(count), 32'(mcount));
      checkOutput("D_valid", 32'(D_valid), 32'(mcount != 0));
      checkOutput("npc_stall", 32'(npc_stall), 32'(mstall));
      if (mcount == 0) begin
        checkOutput("empty_D_PC", D_PC, 32'h0);
        checkOutput("empty_D_Instr", D_Instr, 32'h0);
      end
    end
    if (rst || fl) mcount = 0;
    else mcount = mcount + int'(mpush) - int'(mpop);
  endtask

  // Monitor: every accepted head entry must match the oldest scoreboard entry.
  initial begin
    logic [63:0] exp_e;
    forever begin
      @(negedge CLK);
      #2;
      if (!Reset && !Flush && D_valid && D_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL pop_unexpected: got PC %h with empty scoreboard", D_PC);
        end else begin
          exp_e = exp_q.pop_front();
          checkOutput("pop_PC", D_PC, exp_e[63:32]);
          checkOutput("pop_Instr", D_Instr, exp_e[31:0]);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; F_valid = 1'b0; Flush = 1'b0; D_ready = 1'b0;
    F_PC = 32'h0; F_Instr = 32'h0;
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);

    // Single push, then fill to full with decode stalled
    applyStimulus(0, 1, 0, 0, 32'h3000, 32'h24010001);
    applyStimulus(0, 1, 0, 0, 32'h3004, 32'h24020002);
    applyStimulus(0, 1, 0, 0, 32'h3008, 32'h24030003);
    applyStimulus(0, 1, 0, 0, 32'h300C, 32'h24040004);
    applyStimulus(0, 1, 0, 0, 32'h3010, 32'h24050005);
    // Full with decode ready: pop and push on the same edge, then drain across the wrap
    applyStimulus(0, 1, 0, 1, 32'h3010, 32'h24050005);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);

    // Flush with three entries held and decode ready
    applyStimulus(0, 1, 0, 0, 32'h3014, 32'h24060006);
    applyStimulus(0, 1, 0, 0, 32'h3018, 32'h24070007);
    applyStimulus(0, 1, 0, 0, 32'h301C, 32'h24080008);
    applyStimulus(0, 1, 1, 1, 32'h3020, 32'h24090009);
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);

    // Streaming with decode always ready
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 1, 0, 1, 32'h3000 + 32'(4 * i), 32'h24100000 + 32'(i));
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);

    // Reset and Flush together mid-stream
    applyStimulus(0, 1, 0, 0, 32'h3100, 32'h24200001);
    applyStimulus(0, 1, 0, 0, 32'h3104, 32'h24200002);
    applyStimulus(1, 1, 1, 1, 32'h3108, 32'h24200003);
    applyStimulus(0, 1, 0, 0, 32'h3040, 32'h24300001);
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
